add_issue_sched: RTL
====================

ADD_ISSUE_SCHED -- requirements
Module: add_issue_sched

Interface
- REQ-001: Parameter EXEC_LAT, default 2: add/sub execution latency in cycles, legal range 1..15.
- REQ-002: clk1  input  1  sole clock; all state SHALL update on the rising edge.
- REQ-003: rst_n  input  1  asynchronous, active-low reset.
- REQ-004: rs_busy  input  3  add reservation-station entry occupied, one bit per entry.
- REQ-005: rs_rdy1, rs_rdy2  input  3 each  operand-1 and operand-2 valid flags, one bit per entry.
- REQ-006: rs_rob  input  9  ROB index of each entry; entry i occupies bits [3i+2:3i].
- REQ-007: rob_head  input  3  current ROB head index.
- REQ-008: ex_b  output  2  one-cycle start pulse per add exec unit.
- REQ-009: issue_rs  output  2  RS entry index accompanying ex_b.
- REQ-010: unit_busy  output  2  exec unit not IDLE.
- REQ-011: cdb_req, cdb_rs  output  1, 2  writeback request and the RS entry it belongs to.
- REQ-012: cdb_gnt  input  1  CDB grant; honoured only while cdb_req=1.
- REQ-013: rs_free  output  3  one-cycle pulse releasing an RS entry after writeback.

Function
- REQ-014: Entry i SHALL be a candidate when rs_busy, rs_rdy1 and rs_rdy2 are all 1 and in-flight mask bit i is 0.
- REQ-015: Each unit SHALL run the FSM IDLE -> EXEC -> WB -> IDLE.
- REQ-016: When at least one unit is IDLE and a candidate exists, the scheduler SHALL issue at most one entry per cycle, to the lowest-numbered IDLE unit.
- REQ-017: On issue, ex_b[u] and issue_rs SHALL be registered and asserted in the following cycle for exactly one cycle, and in-flight bit i SHALL be set on the same edge.
- REQ-018: On issue, the unit SHALL enter EXEC with its counter loaded to EXEC_LAT; the counter SHALL decrement each cycle; at 1 the unit SHALL move to WB.
- REQ-019: In WB, cdb_req=1 and cdb_rs=entry; if both units are in WB, unit 0 SHALL be presented first and unit 1 SHALL hold.
- REQ-020: On cdb_gnt with cdb_req=1, the presented unit SHALL return to IDLE on that edge and rs_free[entry] SHALL pulse in the next cycle.
- REQ-021: A unit returning to IDLE SHALL be eligible for issue in the same cycle it becomes IDLE.
- REQ-022: In-flight bit i SHALL clear only when rs_busy[i]=0 is sampled after rs_free[i]; a still-busy entry SHALL never re-issue.
- REQ-023: Default selection SHALL be round-robin over entries 0..2, starting after the last issued entry; the pointer SHALL wrap 2 -> 0.
- REQ-024: A candidate whose rs_busy drops before issue SHALL be dropped silently.

Reset
- REQ-025: On rst_n=0, all units SHALL go to IDLE, counters, in-flight mask and RR pointer SHALL clear, and ex_b, issue_rs, unit_busy, cdb_req, cdb_rs and rs_free SHALL be 0.
- REQ-026: Reset mid-operation SHALL discard in-flight and WB results without issuing a rs_free pulse.

Configuration
- REQ-027: With ADD_SCHED_AGE_PRIO_EN defined, selection SHALL choose the oldest candidate, where age = (rs_rob[i] - rob_head) mod 8 and the smallest age wins; without the macro, REQ-023 round-robin SHALL apply and rob_head SHALL be ignored.

Structure
- REQ-028: The shared package tomasulo_pkg SHALL hold RS_DEPTH=3, N_ADD_UNITS=2, ROB_IDX_W=3 and the unit-state enum {IDLE, EXEC, WB}.
- REQ-029: The per-unit FSM and counter SHALL be the sub-module add_unit_tracker, instantiated N_ADD_UNITS times.

Verification
- REQ-030: Single issue: entry 1 ready with EXEC_LAT=2 -> ex_b=01 and issue_rs=1 one cycle later; cdb_req two cycles after that; with cdb_gnt held at 1, rs_free=010 one cycle after the grant.
- REQ-031: Three entries ready at once -> issues go to units 0 and 1 on consecutive cycles; the third entry waits until a unit is IDLE.
- REQ-032: Both units reach WB together with cdb_gnt=0 for 3 cycles -> unit 0 is presented first and unit 1 holds, and no issue occurs; when the grant arrives, unit 0 frees first, then unit 1.
- REQ-033: Age mode with rob_head=6 and rs_rob entries {7,1,6} -> entry 2 issues first, then 0, then 1 (wrap-around).
- REQ-034: Reset asserted while unit 0 is in EXEC -> all outputs 0 immediately and no rs_free pulse; after release, a ready entry issues normally.
- REQ-035: rs_busy held high after rs_free -> the entry is never re-issued.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared sizes, unit-state enum
// and index helpers for the add issue scheduler.
package tomasulo_pkg;

  localparam int RS_DEPTH    = 3;
  localparam int N_ADD_UNITS = 2;
  localparam int ROB_IDX_W   = 3;
  localparam int RS_IDX_W    = 2;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } unit_state_e;

  typedef logic [RS_IDX_W-1:0]  rs_idx_t;
  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  // distance from the ROB head, modulo ROB size
  function automatic rob_idx_t rob_age(
    input rob_idx_t rob,
    input rob_idx_t head
  );
    return rob - head;
  endfunction

  // next RS entry, wrapping at the last one
  function automatic rs_idx_t rs_next(
    input rs_idx_t i
  );
    rs_idx_t last;
    last = rs_idx_t'(RS_DEPTH - 1);
    return (i == last) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/add_unit_tracker.sv
// add_unit_tracker: IDLE/EXEC/WB sequencer and
// latency countdown for one add exec unit.
module add_unit_tracker
  import tomasulo_pkg::*;
#(
  parameter int EXEC_LAT = 2
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        i_start,
  input  rs_idx_t     i_entry,
  input  logic        i_done,
  output unit_state_e o_state,
  output rs_idx_t     o_entry
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(EXEC_LAT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  unit_state_e      r_state;
  unit_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  rs_idx_t          r_entry;
  rs_idx_t          w_entry_nxt;

  // state, countdown and owning RS entry
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_entry <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_entry <= w_entry_nxt;
    end
  end

  // next state: count down in EXEC, hold in WB until granted
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_entry_nxt = r_entry;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = EXEC;
          w_cnt_nxt   = LAT;
          w_entry_nxt = i_entry;
        end
      end
      EXEC: begin
        if (r_cnt <= ONE) begin
          w_state_nxt = WB;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - ONE;
        end
      end
      WB: begin
        if (i_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_state = r_state;
  assign o_entry = r_entry;

endmodule

// File: rtl/add_issue_sched.sv
// add_issue_sched: issues ready add RS entries to two exec units.
// ADD_SCHED_AGE_PRIO_EN: oldest-by-ROB selection instead of round-robin.
module add_issue_sched
  import tomasulo_pkg::*;
#(
  parameter int EXEC_LAT = 2
) (
  input  logic                          clk1,
  input  logic                          rst_n,
  input  logic [RS_DEPTH-1:0]           rs_busy,
  input  logic [RS_DEPTH-1:0]           rs_rdy1,
  input  logic [RS_DEPTH-1:0]           rs_rdy2,
  input  logic [RS_DEPTH*ROB_IDX_W-1:0] rs_rob,
  input  logic [ROB_IDX_W-1:0]          rob_head,
  output logic [N_ADD_UNITS-1:0]        ex_b,
  output logic [RS_IDX_W-1:0]           issue_rs,
  output logic [N_ADD_UNITS-1:0]        unit_busy,
  output logic                          cdb_req,
  output logic [RS_IDX_W-1:0]           cdb_rs,
  input  logic                          cdb_gnt,
  output logic [RS_DEPTH-1:0]           rs_free
);

  localparam logic [N_ADD_UNITS-1:0] ONE_U  = 1;
  localparam logic [RS_DEPTH-1:0]    ONE_RS = 1;

  unit_state_e            w_st  [N_ADD_UNITS];
  rs_idx_t                w_ent [N_ADD_UNITS];
  logic [N_ADD_UNITS-1:0] w_idle;
  logic [N_ADD_UNITS-1:0] w_wb;
  logic [N_ADD_UNITS-1:0] w_start;
  logic [N_ADD_UNITS-1:0] w_done;
  logic [RS_DEPTH-1:0]    w_cand;
  logic [RS_DEPTH-1:0]    w_set;
  logic [RS_DEPTH-1:0]    w_fin;
  logic [RS_DEPTH-1:0]    w_clr;
  logic                   w_unit;
  logic                   w_pres;
  logic                   w_issue;
  logic                   w_grant;
  logic                   w_found;
  rs_idx_t                w_sel;
  logic                   w_unused;

  logic [N_ADD_UNITS-1:0] r_ex_b;
  rs_idx_t                r_issue_rs;
  logic [RS_DEPTH-1:0]    r_rs_free;
  logic [RS_DEPTH-1:0]    r_infl;
  logic [RS_DEPTH-1:0]    r_done;
  rs_idx_t                r_rr;

  for (genvar u = 0; u < N_ADD_UNITS; u++) begin : g_unit
    add_unit_tracker #(
      .EXEC_LAT (EXEC_LAT)
    ) u_trk (
      .clk1    (clk1),
      .rst_n   (rst_n),
      .i_start (w_start[u]),
      .i_entry (w_sel),
      .i_done  (w_done[u]),
      .o_state (w_st[u]),
      .o_entry (w_ent[u])
    );
    assign w_idle[u] = (w_st[u] == IDLE);
    assign w_wb[u]   = (w_st[u] == WB);
  end

  assign w_cand = rs_busy & rs_rdy1 & rs_rdy2 & ~r_infl;

`ifdef ADD_SCHED_AGE_PRIO_EN
  rob_idx_t w_age;
  rob_idx_t w_best;

  // oldest candidate relative to the ROB head
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    w_best  = '1;
    w_age   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_age = rob_age(rs_rob[ROB_IDX_W*i +: ROB_IDX_W], rob_head);
      if (w_cand[i] && (!w_found || (w_age < w_best))) begin
        w_found = 1'b1;
        w_best  = w_age;
        w_sel   = rs_idx_t'(i);
      end
    end
  end

  assign w_unused = ^r_rr;
`else
  rs_idx_t w_idx;

  // first candidate at or after the round-robin pointer
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    w_idx   = r_rr;
    for (int k = 0; k < RS_DEPTH; k++) begin
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
      w_idx = rs_next(w_idx);
    end
  end

  assign w_unused = ^{rs_rob, rob_head};
`endif

  // lowest-numbered idle unit takes the issue
  always_comb begin
    w_unit = 1'b0;
    priority case (1'b1)
      w_idle[0]: w_unit = 1'b0;
      w_idle[1]: w_unit = 1'b1;
      default:   w_unit = 1'b0;
    endcase
  end

  // unit 0 owns the CDB when both wait in WB
  always_comb begin
    w_pres = 1'b0;
    priority case (1'b1)
      w_wb[0]: w_pres = 1'b0;
      w_wb[1]: w_pres = 1'b1;
      default: w_pres = 1'b0;
    endcase
  end

  assign w_issue = (|w_idle) & w_found;
  assign w_start = w_issue ? (ONE_U << w_unit) : '0;
  assign cdb_req = |w_wb;
  assign cdb_rs  = w_ent[w_pres];
  assign w_grant = cdb_req & cdb_gnt;
  assign w_done  = w_grant ? (ONE_U << w_pres) : '0;
  assign w_set   = w_issue ? (ONE_RS << w_sel) : '0;
  assign w_fin   = w_grant ? (ONE_RS << cdb_rs) : '0;
  assign w_clr   = r_done & ~rs_busy;

  // issue/free pulses, in-flight tracking, RR pointer
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_b     <= '0;
      r_issue_rs <= '0;
      r_rs_free  <= '0;
      r_infl     <= '0;
      r_done     <= '0;
      r_rr       <= '0;
    end else begin
      r_ex_b     <= w_start;
      r_issue_rs <= w_issue ? w_sel : '0;
      r_rs_free  <= w_fin;
      r_infl     <= (r_infl & ~w_clr) | w_set;
      r_done     <= (r_done & ~w_clr) | w_fin;
      if (w_issue) begin
        r_rr <= rs_next(w_sel);
      end
    end
  end

  assign ex_b     = r_ex_b;
  assign issue_rs = r_issue_rs;
  assign rs_free  = r_rs_free;
  assign unit_busy = ~w_idle;

endmodule
